// File: rtl/pred_tracker_if.sv
// Shared types and the fetch/execute-facing bundle of pred_tracker.
// XLEN is fixed here so that the bpu-facing structs match across users.
package pred_tracker_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } prediction_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } resolution_t;
endpackage

// Handshake and result signals between fetch/execute and the tracker.
// The tracker uses the slave view; fetch/execute (or a bench) uses master.
interface pred_tracker_if;
  logic                             flush_i;
  logic                             enq_valid_i;
  logic                             enq_ready_o;
  logic [pred_tracker_pkg::XLEN-1:0] enq_pc_i;
  pred_tracker_pkg::prediction_t    enq_pred_i;
  logic                             ex_valid_i;
  logic [pred_tracker_pkg::XLEN-1:0] ex_pc_i;
  logic                             ex_taken_i;
  logic [pred_tracker_pkg::XLEN-1:0] ex_target_i;
  pred_tracker_pkg::resolution_t    res_o;
  logic                             redirect_o;
  logic [pred_tracker_pkg::XLEN-1:0] redirect_pc_o;

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_pred_i,
    output ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
    input  enq_ready_o, res_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_pred_i,
    input  ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
    output enq_ready_o, res_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/pred_tracker.sv
// pred_tracker: queues bpu predictions from fetch, checks them against the
// branch outcome resolved in execute, trains bpu and redirects fetch.
// Optional feature macro: PRED_TRACKER_STATS_EN adds saturating resolve and
// mispredict counters (stat_res_o / stat_misp_o).
module pred_tracker
  import pred_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  pred_tracker_if.slave bus
`ifdef PRED_TRACKER_STATS_EN
  ,
  output logic [31:0]   stat_res_o,
  output logic [31:0]   stat_misp_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [XLEN-1:0] pc_mem_q     [DEPTH];
  logic [XLEN-1:0] target_mem_q [DEPTH];
  logic            taken_mem_q  [DEPTH];

  logic            full, empty, head_valid, head_taken;
  logic [XLEN-1:0] head_target;
  logic            misp, push, pop, clear, enq_ready;

  resolution_t     res_q, res_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  // Head lookup and mispredict decision; an empty queue or RECOVER falls back to the not-taken default.
  always_comb begin
    wr_idx      = wr_ptr_q[AW-1:0];
    rd_idx      = rd_ptr_q[AW-1:0];
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    head_valid  = !empty && (state_q == RUN);
    head_taken  = 1'b0;
    head_target = '0;
    if (head_valid) begin
      head_taken  = taken_mem_q[rd_idx];
      head_target = target_mem_q[rd_idx];
    end
    misp  = (bus.ex_taken_i != head_taken) ||
            (bus.ex_taken_i && (bus.ex_target_i != head_target));
    push  = bus.enq_valid_i && enq_ready;
    pop   = bus.ex_valid_i && head_valid;
    clear = bus.flush_i || (bus.ex_valid_i && misp);
  end

  // Pointer update; a flush or mispredict wipes everything, including a same-cycle enqueue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers; reset discards all entries immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset since the pointers define which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_idx]     <= bus.enq_pc_i;
      taken_mem_q[wr_idx]  <= bus.enq_pred_i.taken;
      target_mem_q[wr_idx] <= bus.enq_pred_i.target;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM next state: a mispredict in RUN costs one RECOVER cycle; flush always forces RUN.
  always_comb begin
    state_d = RUN;
    if (!bus.flush_i && (state_q == RUN) && bus.ex_valid_i && misp) state_d = RECOVER;
  end

  // FSM outputs: readiness is purely registered so execute never loops back into fetch.
  always_comb begin
    enq_ready = !full && (state_q == RUN);
  end

  // Next resolution and redirect; flush keeps the training result but silences the redirect.
  always_comb begin
    res_d         = '0;
    redirect_d    = bus.ex_valid_i && misp && !bus.flush_i;
    redirect_pc_d = redirect_pc_q;
    if (bus.ex_valid_i) begin
      res_d.valid      = 1'b1;
      res_d.pc         = bus.ex_pc_i;
      res_d.target     = bus.ex_target_i;
      res_d.taken      = bus.ex_taken_i;
      res_d.mispredict = misp;
    end
    if (redirect_d) begin
      redirect_pc_d = bus.ex_taken_i ? bus.ex_target_i : (bus.ex_pc_i + XLEN'(4));
    end
  end

  // Registered resolution and redirect outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      res_q         <= res_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.enq_ready_o   = enq_ready;
  assign bus.res_o         = res_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;

`ifdef PRED_TRACKER_STATS_EN
  logic [31:0] stat_res_q, stat_misp_q;

  // Saturating resolve/mispredict counters, cleared by flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_res_q  <= '0;
      stat_misp_q <= '0;
    end else if (bus.flush_i) begin
      stat_res_q  <= '0;
      stat_misp_q <= '0;
    end else if (bus.ex_valid_i) begin
      if (stat_res_q != '1)         stat_res_q  <= stat_res_q + 32'd1;
      if (misp && stat_misp_q != '1) stat_misp_q <= stat_misp_q + 32'd1;
    end
  end

  assign stat_res_o  = stat_res_q;
  assign stat_misp_o = stat_misp_q;
`endif

  // Execute must resolve in fetch order; a PC mismatch on pop is an upstream bug.
  a_ex_order: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    pop |-> (bus.ex_pc_i == pc_mem_q[rd_idx]));

endmodule
